int_acc_driver: RTL and testbench
=================================

# int_acc_driver

Self-checking stimulus source for the integer-accumulator stream test systems. It transmits a bounded arithmetic sequence of 32-bit integers over an ESI valid/ready channel into an accumulator under test. It receives one running-total response per accepted word and checks each response against its own running sum. It reports done/pass/error status on raw ports for the top-level testbench.

## Interface
Parameters:
- NUM_WORDS, 16: words to transmit per run; must be 1..65535.
- START, 32'd1: first data word.
- STEP, 32'd1: increment between consecutive words, modulo 2^32.
- MAX_OUTSTANDING, 2: maximum words accepted but not yet answered; also the expected-total FIFO depth; must be 1..8.
- TIMEOUT, 1000: idle-cycle limit while waiting for a response; used only with the macro.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous, active-low reset.
- ints  IValidReady_i32.sink  32 data + valid/ready  outgoing word stream; this block drives valid and data.
- totalIn  IValidReady_i32.source  32 data + valid/ready  incoming running-total responses; this block drives ready.
- done  output  1  run finished; sticky.
- pass  output  1  done && errCount==0 && !timeout.
- errCount  output  16  response mismatch count; saturates at 16'hFFFF.
- timeout  output  1  watchdog fired; sticky; constant 0 without the macro.

## Operation
- Single clock, one always_ff with async reset. Reset clears all state.
- Reset values: ints.valid=0, ints.data=START, totalIn.ready=0, done=0, pass=0, errCount=0, timeout=0.
- State machine:
  - RUN: transmit words and check responses.
    - Go to DRAIN on the handshake that accepts word NUM_WORDS.
  - DRAIN: keep ints.valid low and keep checking responses.
    - Go to DONE when outstanding reaches 0.
  - DONE: ints.valid=0, totalIn.ready=0, done=1.
    - Stays in DONE until reset.
- Send rule: ints.valid is registered. It is 1 in RUN whenever next-cycle outstanding < MAX_OUTSTANDING.
- Once asserted, ints.valid and ints.data hold stable until ints.valid && ints.ready.
- Word accept (ints.valid && ints.ready at a clock edge):
  - sentCount++.
  - runSum <= runSum + data.
  - Push runSum + data into the expected FIFO.
  - ints.data <= data + STEP.
- Response (totalIn.valid && totalIn.ready at a clock edge):
  - FIFO not empty: pop the head; if totalIn.data != head, errCount++.
  - FIFO empty: unexpected response; errCount++, no pop.
- Push and pop at the same edge: outstanding is unchanged. The pop compares against the old head; pop-before-push ordering applies.
- Arithmetic is unsigned modulo 2^32 and wraps silently. errCount saturates and never wraps.
- outstanding is a counter of width clog2(MAX_OUTSTANDING+1). It can never exceed MAX_OUTSTANDING because of the send rule.
- totalIn.ready is registered: 1 in RUN and DRAIN, 0 in reset and DONE.

## Timing
- ints.valid first rises on the first clk edge after rstn deasserts, provided the send rule allows it.
- Back-to-back accepts are sustained at 1 word/cycle while outstanding < MAX_OUTSTANDING.
- With MAX_OUTSTANDING=1: at most one word is in flight, and ints.valid is low from the accept cycle until the response handshake.
- Response check result (errCount update) is visible one cycle after the handshake edge.
- done rises on the edge after the final response pop (DRAIN→DONE). pass is valid in the same cycle.
- Reset asserted mid-run: all outputs go to reset values immediately (asynchronously), the FIFO is emptied, and a fresh run starts after deassertion.

## Configuration
- Macro INT_ACC_DRIVER_TIMEOUT_EN.
  - Defined:
    - An idle counter increments each cycle in RUN/DRAIN where outstanding>0 and no response handshake occurs.
    - The counter clears on any response handshake or when outstanding==0.
    - When it reaches TIMEOUT: timeout<=1 and the FSM goes to DONE. pass is then 0.
  - Undefined: no counter logic; timeout tied to 0; the block waits indefinitely.

## Test plan
- Zero-latency accumulator model, NUM_WORDS=4, START=1, STEP=1 → responses 1,3,6,10; done=1, errCount=0, pass=1.
- Accumulator model that drops ints.ready randomly ~25% of cycles and delays responses 0-5 cycles, MAX_OUTSTANDING=2:
  - ints.data stays stable while stalled.
  - outstanding never exceeds 2.
  - pass=1 after 16 words (final total 136).
- Wrap case: START=32'hFFFFFFFF, STEP=1, NUM_WORDS=3 → words FFFFFFFF, 0, 1; expected totals FFFFFFFF, FFFFFFFF, 0; pass=1.
- Corrupted response: model returns 7 instead of 6 for the third word → errCount=1, pass=0, done=1.
- Unsolicited response while the FIFO is empty → errCount increments, no underflow; a later correct run sequence still completes with done=1.
- With INT_ACC_DRIVER_TIMEOUT_EN and TIMEOUT=20, the model never responds:
  - timeout=1 exactly 20 cycles after the first accept.
  - done=1, pass=0.
  - Also pulse rstn low mid-run: all outputs return to reset values and a rerun passes.

Source files
------------

// File: rtl/int_acc_driver_if.sv
// 32-bit valid/ready stream channel between the accumulator driver and the
// accumulator under test. sink/master is the side that drives valid and data;
// source/slave is the side that drives ready.
interface int_acc_driver_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;

    modport sink   (output valid, output data, input  ready);
    modport source (input  valid, input  data, output ready);
    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/int_acc_driver.sv
// int_acc_driver: sends a bounded arithmetic sequence of 32-bit words to an
// accumulator, keeps its own running sum, and checks each running-total
// response against a FIFO of expected totals. Reports done/pass/errCount.
// Optional watchdog: define INT_ACC_DRIVER_TIMEOUT_EN to abort the run when
// no response arrives for TIMEOUT cycles while words are outstanding.
module int_acc_driver #(
    parameter int unsigned NUM_WORDS       = 16,
    parameter logic [31:0] START           = 32'd1,
    parameter logic [31:0] STEP            = 32'd1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT         = 1000
) (
    input  logic                   clk,
    input  logic                   rstn,
    int_acc_driver_if.sink         ints,
    int_acc_driver_if.source       totalIn,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            errCount,
    output logic                   timeout
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    if (NUM_WORDS < 1 || NUM_WORDS > 65535 || MAX_OUTSTANDING < 1 ||
        MAX_OUTSTANDING > 8 || TIMEOUT < 1) begin : g_bad_params
        $error("int_acc_driver: parameter out of range");
    end

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t           state, state_next;
    logic [31:0]      fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] outstanding, outstanding_next;
    logic [15:0]      sent_count, err_next;
    logic [31:0]      send_data, run_sum, sum_next;
    logic             send_valid, rsp_ready;
    logic             accept, respond, pop, mismatch, timeout_next;

    // Saturating error counter increment; never wraps back to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Circular pointer advance over a FIFO that need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ints.valid    = send_valid;
    assign ints.data     = send_data;
    assign totalIn.ready = rsp_ready;

`ifdef INT_ACC_DRIVER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_tick;
    assign idle_tick = (state != DONE) && (outstanding != '0) && !respond;
`endif

    // Handshake decode, response check and next-state selection.
    always_comb begin
        accept           = send_valid && ints.ready;
        respond          = totalIn.valid && rsp_ready;
        pop              = respond && (outstanding != '0);
        // Pop compares against the current head, before any same-edge push.
        mismatch         = respond && ((outstanding == '0) || (totalIn.data != fifo[rd_ptr]));
        err_next         = mismatch ? sat_inc(errCount) : errCount;
        sum_next         = run_sum + send_data;
        outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(pop);
        timeout_next     = timeout;
`ifdef INT_ACC_DRIVER_TIMEOUT_EN
        if (idle_tick && (idle_cnt == IDLE_W'(TIMEOUT - 1)))
            timeout_next = 1'b1;
`endif
        state_next = state;
        case (state)
            RUN:     if (accept && (sent_count == 16'(NUM_WORDS - 1))) state_next = DRAIN;
            DRAIN:   if (outstanding_next == '0) state_next = DONE;
            default: state_next = DONE;
        endcase
        if (timeout_next)
            state_next = DONE;
    end

    // Run FSM, expected-total FIFO and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= RUN;
            send_valid  <= 1'b0;
            send_data   <= START;
            rsp_ready   <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            errCount    <= '0;
            timeout     <= 1'b0;
            sent_count  <= '0;
            run_sum     <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++)
                fifo[i] <= '0;
`ifdef INT_ACC_DRIVER_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
        end else begin
            state       <= state_next;
            // valid only when the word could be accepted without overrunning the FIFO
            send_valid  <= (state_next == RUN) && (outstanding_next < CNT_W'(MAX_OUTSTANDING));
            rsp_ready   <= (state_next != DONE);
            done        <= (state_next == DONE);
            pass        <= (state_next == DONE) && (err_next == '0) && !timeout_next;
            errCount    <= err_next;
            timeout     <= timeout_next;
            outstanding <= outstanding_next;
            if (accept) begin
                sent_count   <= sent_count + 16'd1;
                run_sum      <= sum_next;
                fifo[wr_ptr] <= sum_next;
                wr_ptr       <= ptr_inc(wr_ptr);
                send_data    <= send_data + STEP;
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
`ifdef INT_ACC_DRIVER_TIMEOUT_EN
            idle_cnt <= idle_tick ? idle_cnt + 1'b1 : '0;
`endif
        end
    end
endmodule

// File: tb/tb_int_acc_driver.sv
// Bench for int_acc_driver: an accumulator model answers the driver's words,
// with optional stalls, delays, a corrupted total and an unsolicited response.
module tb_int_acc_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_a, rstn_w;
    int          sel;
    logic        m_ready, m_tvalid;
    logic [31:0] m_tdata;

    int_acc_driver_if ints_a ();
    int_acc_driver_if tot_a ();
    int_acc_driver_if ints_w ();
    int_acc_driver_if tot_w ();

    logic        done_a, pass_a, to_a, done_w, pass_w, to_w;
    logic [15:0] err_a, err_w;

    int_acc_driver #(.NUM_WORDS(16), .START(32'd1), .STEP(32'd1),
                     .MAX_OUTSTANDING(2), .TIMEOUT(20)) u_a (
        .clk(clk), .rstn(rstn_a), .ints(ints_a), .totalIn(tot_a),
        .done(done_a), .pass(pass_a), .errCount(err_a), .timeout(to_a));

    int_acc_driver #(.NUM_WORDS(3), .START(32'hFFFFFFFF), .STEP(32'd1),
                     .MAX_OUTSTANDING(2), .TIMEOUT(20)) u_w (
        .clk(clk), .rstn(rstn_w), .ints(ints_w), .totalIn(tot_w),
        .done(done_w), .pass(pass_w), .errCount(err_w), .timeout(to_w));

    // Model drives whichever DUT is selected; the other sees idle inputs.
    assign ints_a.ready = (sel == 0) && m_ready;
    assign tot_a.valid  = (sel == 0) && m_tvalid;
    assign tot_a.data   = m_tdata;
    assign ints_w.ready = (sel == 1) && m_ready;
    assign tot_w.valid  = (sel == 1) && m_tvalid;
    assign tot_w.data   = m_tdata;

    logic        s_valid, s_tready, s_done, s_pass, s_to;
    logic [31:0] s_data;
    logic [15:0] s_err;
    assign s_valid  = (sel == 0) ? ints_a.valid : ints_w.valid;
    assign s_data   = (sel == 0) ? ints_a.data  : ints_w.data;
    assign s_tready = (sel == 0) ? tot_a.ready  : tot_w.ready;
    assign s_done   = (sel == 0) ? done_a : done_w;
    assign s_pass   = (sel == 0) ? pass_a : pass_w;
    assign s_to     = (sel == 0) ? to_a   : to_w;
    assign s_err    = (sel == 0) ? err_a  : err_w;

    typedef struct {
        logic [31:0] val;
        bit          bad;
        int          due;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [31:0] exp_w[$];
    int          err_q[$];
    int          n_checks, n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input logic [31:0] start);
        check_eq("rst_valid", 32'(s_valid), 32'd0);
        check_eq("rst_data", s_data, start);
        check_eq("rst_ready", 32'(s_tready), 32'd0);
        check_eq("rst_done", 32'(s_done), 32'd0);
        check_eq("rst_pass", 32'(s_pass), 32'd0);
        check_eq("rst_err", {16'd0, s_err}, 32'd0);
        check_eq("rst_timeout", 32'(s_to), 32'd0);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic pulse_reset(input int which, input logic [31:0] start);
        sel = which;
        @(posedge clk);
        #2;
        if (which == 0) rstn_a = 1'b0; else rstn_w = 1'b0;
        m_ready  = 1'b0;
        m_tvalid = 1'b0;
        #1;
        check_reset(start);
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input int which, input logic [31:0] start, input int n,
                       input bit rnd, input int corrupt_idx, input bit unsol,
                       input int abort_after, input logic [31:0] exp_final);
        int          accepted, responded, max_out, exp_err;
        logic [31:0] msum, prev_data;
        bit          prev_stall, finished;
        rsp_t        r;
        sel = which;
        m_ready = 1'b0; m_tvalid = 1'b0; m_tdata = '0;
        rsp_q.delete(); exp_w.delete(); err_q.delete();
        for (int i = 0; i < n; i++) exp_w.push_back(start + 32'(i));
        msum = '0; prev_data = '0; accepted = 0; responded = 0; max_out = 0;
        exp_err = 0; prev_stall = 0; finished = 0;
        @(negedge clk);
        if (which == 0) rstn_a = 1'b1; else rstn_w = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (err_q.size() > 0) check_eq("err_count", {16'd0, s_err}, 32'(err_q.pop_front()));
            if (cyc == 0) check_eq("valid_first_edge", 32'(s_valid), 32'd1);
            if (prev_stall) begin
                check_eq("stall_valid", 32'(s_valid), 32'd1);
                check_eq("stall_data", s_data, prev_data);
            end
            if ((abort_after > 0 && cyc == abort_after) ||
                (accepted == n && rsp_q.size() == 0)) begin
                finished = 1;
                break;
            end
            m_tvalid = 1'b0;
            if (unsol && cyc == 0) begin
                m_tvalid = 1'b1;
                m_tdata  = 32'h55;
                if (s_tready) begin
                    exp_err++;
                    err_q.push_back(exp_err);
                end
            end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                m_tvalid = 1'b1;
                m_tdata  = rsp_q[0].val;
                if (s_tready) begin
                    r = rsp_q.pop_front();
                    responded++;
                    if (r.bad) exp_err++;
                    err_q.push_back(exp_err);
                end
            end
            m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (unsol && cyc == 0) m_ready = 1'b0;
            prev_stall = s_valid && !m_ready;
            prev_data  = s_data;
            if (s_valid && m_ready) begin
                if (exp_w.size() == 0) check_eq("extra_word", 32'(accepted), 32'(n));
                else check_eq("word", s_data, exp_w.pop_front());
                msum  = msum + s_data;
                r.bad = (accepted == corrupt_idx);
                r.val = r.bad ? msum + 32'd1 : msum;
                r.due = cyc + 1 + (rnd ? int'($urandom_range(0, 5)) : 0);
                rsp_q.push_back(r);
                accepted++;
            end
            if (accepted - responded > max_out) max_out = accepted - responded;
        end
        m_ready = 1'b0;
        m_tvalid = 1'b0;
        if (!finished) begin
            check_eq("cycle_budget", 32'd0, 32'd1);
        end else if (abort_after == 0) begin
            check_eq("done", 32'(s_done), 32'd1);
            check_eq("pass", 32'(s_pass), 32'(exp_err == 0));
            check_eq("err_final", {16'd0, s_err}, 32'(exp_err));
            check_eq("timeout_off", 32'(s_to), 32'd0);
            check_eq("done_valid", 32'(s_valid), 32'd0);
            check_eq("done_ready", 32'(s_tready), 32'd0);
            check_eq("max_outstanding", 32'(max_out <= 2), 32'd1);
            check_eq("final_total", msum, exp_final);
            check_eq("words_sent", 32'(accepted), 32'(n));
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        sel = 0; rstn_a = 1'b0; rstn_w = 1'b0;
        m_ready = 1'b0; m_tvalid = 1'b0; m_tdata = '0;
        repeat (3) @(negedge clk);
        check_reset(32'd1);
        sel = 1;
        #1 check_reset(32'hFFFFFFFF);

        // zero-latency accumulator, 16 words 1..16
        run(0, 32'd1, 16, 1'b0, -1, 1'b0, 0, 32'd136);
        pulse_reset(0, 32'd1);
        // random stalls and response delays
        run(0, 32'd1, 16, 1'b1, -1, 1'b0, 0, 32'd136);
        pulse_reset(0, 32'd1);
        // third response returned as 7 instead of 6
        run(0, 32'd1, 16, 1'b0, 2, 1'b0, 0, 32'd136);
        pulse_reset(0, 32'd1);
        // unsolicited response before any word is outstanding
        run(0, 32'd1, 16, 1'b0, -1, 1'b1, 0, 32'd136);
        pulse_reset(0, 32'd1);
        // abort mid-run with reset, then rerun
        run(0, 32'd1, 16, 1'b1, -1, 1'b0, 6, 32'd0);
        pulse_reset(0, 32'd1);
        run(0, 32'd1, 16, 1'b0, -1, 1'b0, 0, 32'd136);
        // 32-bit wrap: FFFFFFFF, 0, 1 -> totals FFFFFFFF, FFFFFFFF, 0
        run(1, 32'hFFFFFFFF, 3, 1'b0, -1, 1'b0, 0, 32'd0);

`ifdef INT_ACC_DRIVER_TIMEOUT_EN
        begin
            int  c0;
            bit  seen;
            pulse_reset(0, 32'd1);
            sel = 0; c0 = -1; seen = 0;
            @(negedge clk);
            rstn_a = 1'b1;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (c0 >= 0 && c == c0 + 20) check_eq("timeout_before", 32'(s_to), 32'd0);
                if (c0 >= 0 && c == c0 + 21) begin
                    check_eq("timeout_fired", 32'(s_to), 32'd1);
                    check_eq("timeout_done", 32'(s_done), 32'd1);
                    check_eq("timeout_pass", 32'(s_pass), 32'd0);
                    seen = 1;
                    break;
                end
                m_ready = 1'b1;
                if (c0 < 0 && s_valid) c0 = c;
            end
            m_ready = 1'b0;
            if (!seen) check_eq("timeout_budget", 32'd0, 32'd1);
            pulse_reset(0, 32'd1);
            run(0, 32'd1, 16, 1'b0, -1, 1'b0, 0, 32'd136);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
